// File: rtl/banco_pkg.sv
// banco_pkg: shared defaults and main FSM state type for the MIPS register file
package banco_pkg;
    localparam int LARGURA_PADRAO = 32;
    localparam int PROFUNDIDADE_PADRAO = 32;
    localparam int SP_IDX_PADRAO = 29;
    localparam logic [31:0] SP_INIT_PADRAO = 32'h7fffeffc;
    typedef enum logic [1:0] {INIT, IDLE, DUMP} estado_t;
endpackage

// File: rtl/banco_dump_ctrl.sv
// banco_dump_ctrl: streams every register as valid/ready beats
// ports: clock/reset; iniciar starts a dump at index 0; valor is the array
// word at dump_end supplied by the parent; dump_* is the beat stream;
// concluido pulses on the accepted final beat
module banco_dump_ctrl
    import banco_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    localparam int AW = $clog2(PROFUNDIDADE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [LARGURA-1:0] valor,
    input  logic               dump_ready,
    output logic               dump_valid,
    output logic [AW-1:0]      dump_end,
    output logic [LARGURA-1:0] dump_dado,
    output logic               dump_ultimo,
    output logic               concluido
);
    localparam logic [AW-1:0] ULTIMO = AW'(PROFUNDIDADE - 1);
    logic aceito;
    always_comb begin
        aceito = dump_valid && dump_ready;
        dump_ultimo = dump_valid && dump_end == ULTIMO;
        concluido = aceito && dump_ultimo;
        dump_dado = dump_valid ? valor : '0;
    end
    // the counter wraps back to 0 after the last beat, so idle index is 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dump_valid <= 1'b0;
            dump_end <= '0;
        end else if (iniciar) begin
            dump_valid <= 1'b1;
            dump_end <= '0;
        end else if (aceito) begin
            dump_valid <= !dump_ultimo;
            dump_end <= dump_end + 1'b1;
        end
    end
endmodule

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: parametrised MIPS register file with init sweep and debug dump
// ports: clock/reset (async, active-high); wren/end_escrita/dado_escrita write port;
// end_leitura/dado_leitura packed combinational read lanes; pronto after the sweep;
// dump_start plus dump_valid/ready/end/dado/ultimo debug stream
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int                 LARGURA = LARGURA_PADRAO,
    parameter int                 PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int                 N_LEITURA = 2,
    parameter bit                 BYPASS = 1'b1,
    parameter int                 SP_IDX = SP_IDX_PADRAO,
    parameter logic [LARGURA-1:0] SP_INIT = LARGURA'(SP_INIT_PADRAO),
    localparam int                AW = $clog2(PROFUNDIDADE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wren,
    input  logic [AW-1:0]                end_escrita,
    input  logic [LARGURA-1:0]           dado_escrita,
    input  logic [N_LEITURA*AW-1:0]      end_leitura,
    output logic [N_LEITURA*LARGURA-1:0] dado_leitura,
    output logic                         pronto,
    input  logic                         dump_start,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [AW-1:0]                dump_end,
    output logic [LARGURA-1:0]           dump_dado,
    output logic                         dump_ultimo
);
    localparam logic [AW-1:0] ULTIMO = AW'(PROFUNDIDADE - 1);
    localparam logic [AW-1:0] SP = AW'(SP_IDX);
    estado_t estado, proximo;
    logic [AW-1:0] cnt_init, end_w;
    logic [LARGURA-1:0] dado_w;
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic iniciar, concluido, escreve;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INIT;
        else estado <= proximo;
    end
    always_comb begin
        proximo = estado;
        if (estado == INIT && cnt_init == ULTIMO) proximo = IDLE;
        else if (estado == IDLE && dump_start) proximo = DUMP;
        else if (estado == DUMP && concluido) proximo = IDLE;
    end
    // the sweep owns the write port during INIT; register 0 is never written afterwards
    always_comb begin
        pronto = estado != INIT;
        iniciar = estado == IDLE && dump_start;
        escreve = estado == INIT || (wren && end_escrita != '0);
        end_w = estado == INIT ? cnt_init : end_escrita;
        dado_w = estado == INIT ? (cnt_init == SP ? SP_INIT : '0) : dado_escrita;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_init <= '0;
        else if (estado == INIT) cnt_init <= cnt_init + 1'b1;
    end
    always_ff @(posedge clock) begin
        if (escreve) mem[end_w] <= dado_w;
    end
    for (genvar k = 0; k < N_LEITURA; k++) begin : g_leitura
        logic [AW-1:0] ra;
        assign ra = end_leitura[k*AW +: AW];
        assign dado_leitura[k*LARGURA +: LARGURA] =
            estado == INIT ? '0 :
            (BYPASS && wren && end_escrita == ra && ra != '0) ? dado_escrita : mem[ra];
    end
    banco_dump_ctrl #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) u_dump (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .valor      (mem[dump_end]),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_end   (dump_end),
        .dump_dado  (dump_dado),
        .dump_ultimo(dump_ultimo),
        .concluido  (concluido)
    );
endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: randomized self-checking bench against an array model
module tb_banco_registradores_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic wren = 1'b0;
    logic [4:0] end_escrita = '0;
    logic [31:0] dado_escrita = '0;
    logic [9:0] end_leitura = '0;
    logic dump_start = 1'b0, dump_ready = 1'b0;
    logic [63:0] rd_a, rd_b;
    logic pronto_a, pronto_b;
    logic valid_a, valid_b, ultimo_a, ultimo_b;
    logic [4:0] dend_a, dend_b;
    logic [31:0] ddado_a, ddado_b;
    logic wren_c = 1'b0;
    logic [2:0] end_escrita_c = '0;
    logic [15:0] dado_escrita_c = '0;
    logic [11:0] end_leitura_c = '0;
    logic [63:0] rd_c;
    logic pronto_c, valid_c, ultimo_c;
    logic [2:0] dend_c;
    logic [15:0] ddado_c;
    logic [31:0] mdl [32];
    logic [15:0] mdc [8];
    int checks = 0, erros = 0;

    always #5 clock = ~clock;

    banco_registradores_param dut_a (
        .clock(clock), .reset(reset), .wren(wren), .end_escrita(end_escrita),
        .dado_escrita(dado_escrita), .end_leitura(end_leitura), .dado_leitura(rd_a),
        .pronto(pronto_a), .dump_start(dump_start), .dump_valid(valid_a),
        .dump_ready(dump_ready), .dump_end(dend_a), .dump_dado(ddado_a), .dump_ultimo(ultimo_a)
    );
    banco_registradores_param #(.BYPASS(1'b0)) dut_b (
        .clock(clock), .reset(reset), .wren(wren), .end_escrita(end_escrita),
        .dado_escrita(dado_escrita), .end_leitura(end_leitura), .dado_leitura(rd_b),
        .pronto(pronto_b), .dump_start(dump_start), .dump_valid(valid_b),
        .dump_ready(dump_ready), .dump_end(dend_b), .dump_dado(ddado_b), .dump_ultimo(ultimo_b)
    );
    banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(8), .N_LEITURA(4),
                                .SP_IDX(6), .SP_INIT(16'hBEEF)) dut_c (
        .clock(clock), .reset(reset), .wren(wren_c), .end_escrita(end_escrita_c),
        .dado_escrita(dado_escrita_c), .end_leitura(end_leitura_c), .dado_leitura(rd_c),
        .pronto(pronto_c), .dump_start(1'b0), .dump_valid(valid_c),
        .dump_ready(1'b0), .dump_end(dend_c), .dump_dado(ddado_c), .dump_ultimo(ultimo_c)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic init_modelo();
        for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'h7fffeffc : 32'h0;
        for (int i = 0; i < 8; i++) mdc[i] = (i == 6) ? 16'hBEEF : 16'h0;
    endtask

    task automatic espera_init();
        logic [2:0] r;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wren = 1'b1;
            end_escrita = 5'($urandom);
            dado_escrita = $urandom;
            end_leitura = 10'($urandom);
            wren_c = (i < 8);
            end_escrita_c = 3'($urandom);
            dado_escrita_c = 16'($urandom);
            end_leitura_c = 12'($urandom);
            #1;
            verifica("pronto_a_init", 32'(pronto_a), 32'h0);
            verifica("pronto_c_init", 32'(pronto_c), (i >= 8) ? 32'h1 : 32'h0);
            verifica("init_a0", rd_a[31:0], 32'h0);
            verifica("init_a1", rd_a[63:32], 32'h0);
            verifica("init_b1", rd_b[63:32], 32'h0);
            for (int k = 0; k < 4; k++) begin
                r = end_leitura_c[k*3 +: 3];
                verifica($sformatf("init_c%0d", k), 32'(rd_c[k*16 +: 16]),
                         (i >= 8) ? 32'(mdc[r]) : 32'h0);
            end
            @(negedge clock);
        end
        wren = 1'b0;
        wren_c = 1'b0;
        #1;
        verifica("pronto_a_fim", 32'(pronto_a), 32'h1);
        verifica("pronto_b_fim", 32'(pronto_b), 32'h1);
    endtask

    task automatic ciclo(input logic w, input logic [4:0] we, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        logic [4:0] r [2];
        logic [31:0] esp;
        r[0] = r0;
        r[1] = r1;
        @(negedge clock);
        wren = w;
        end_escrita = we;
        dado_escrita = wd;
        end_leitura = {r1, r0};
        #1;
        for (int k = 0; k < 2; k++) begin
            esp = (w && we == r[k] && r[k] != 0) ? wd : mdl[r[k]];
            verifica($sformatf("rd_a%0d[%0d]", k, r[k]), rd_a[k*32 +: 32], esp);
            verifica($sformatf("rd_b%0d[%0d]", k, r[k]), rd_b[k*32 +: 32], mdl[r[k]]);
        end
        @(posedge clock);
        if (w && we != 0) mdl[we] = wd;
    endtask

    task automatic ciclo_c(input logic w, input logic [2:0] we, input logic [15:0] wd,
                           input logic [11:0] ra);
        logic [2:0] r;
        logic [15:0] esp;
        @(negedge clock);
        wren_c = w;
        end_escrita_c = we;
        dado_escrita_c = wd;
        end_leitura_c = ra;
        #1;
        for (int k = 0; k < 4; k++) begin
            r = ra[k*3 +: 3];
            esp = (w && we == r && r != 0) ? wd : mdc[r];
            verifica($sformatf("rd_c%0d[%0d]", k, r), 32'(rd_c[k*16 +: 16]), 32'(esp));
        end
        @(posedge clock);
        if (w && we != 0) mdc[we] = wd;
    endtask

    task automatic faz_dump(input bit alterna, input bit grava);
        int b = 0;
        int ciclos = 0;
        bit fim = 1'b0;
        @(negedge clock);
        wren = 1'b0;
        dump_ready = 1'b0;
        dump_start = 1'b1;
        @(posedge clock);
        while (!fim && ciclos < 200) begin
            @(negedge clock);
            dump_start = (b == 31) ? 1'b1 : 1'($urandom_range(0, 1));
            dump_ready = alterna ? 1'(ciclos % 2) : 1'b1;
            wren = grava && b == 5;
            end_escrita = 5'd20;
            dado_escrita = 32'hCAFEF00D;
            #1;
            verifica("dump_valid_a", 32'(valid_a), 32'h1);
            verifica("dump_end_a", 32'(dend_a), 32'(b));
            verifica($sformatf("dump_dado_a[%0d]", b), ddado_a, mdl[b]);
            verifica("dump_ultimo_a", 32'(ultimo_a), (b == 31) ? 32'h1 : 32'h0);
            verifica("dump_end_b", 32'(dend_b), 32'(b));
            verifica($sformatf("dump_dado_b[%0d]", b), ddado_b, mdl[b]);
            @(posedge clock);
            if (wren) mdl[20] = 32'hCAFEF00D;
            if (dump_ready) begin
                fim = (b == 31);
                b++;
            end
            ciclos++;
        end
        verifica("dump_beats", 32'(b), 32'd32);
        @(negedge clock);
        dump_start = 1'b0;
        wren = 1'b0;
        #1;
        verifica("dump_valid_fim_a", 32'(valid_a), 32'h0);
        verifica("dump_ultimo_fim_a", 32'(ultimo_a), 32'h0);
        @(negedge clock);
        #1;
        verifica("dump_restart_ignored", 32'(valid_a), 32'h0);
        verifica("dump_valid_fim_b", 32'(valid_b), 32'h0);
    endtask

    task automatic reset_meio();
        @(negedge clock);
        wren = 1'b0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        @(posedge clock);
        for (int b = 0; b < 10; b++) begin
            @(negedge clock);
            dump_start = 1'b0;
            #1;
            verifica("rst_dump_end", 32'(dend_a), 32'(b));
            @(posedge clock);
        end
        @(negedge clock);
        #1;
        verifica("rst_dump_end10", 32'(dend_a), 32'd10);
        reset = 1'b1;
        #1;
        verifica("rst_valid", 32'(valid_a), 32'h0);
        verifica("rst_end", 32'(dend_a), 32'h0);
        verifica("rst_dado", ddado_a, 32'h0);
        verifica("rst_ultimo", 32'(ultimo_a), 32'h0);
        verifica("rst_pronto", 32'(pronto_a), 32'h0);
        verifica("rst_pronto_c", 32'(pronto_c), 32'h0);
        init_modelo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic w;
        logic [4:0] we, r0, r1;
        logic [2:0] wc;
        logic [15:0] v [5];
        init_modelo();
        repeat (2) @(negedge clock);
        espera_init();
        ciclo(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
        ciclo(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        ciclo(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        ciclo(1'b1, 5'd8, 32'h12345678, 5'd1, 5'd2);
        ciclo(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        ciclo(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd9);
        ciclo(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            we = 5'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? we : 5'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? we : 5'($urandom);
            ciclo(w, we, $urandom, r0, r1);
        end
        ciclo_c(1'b0, 3'd0, 16'h0, {3'd6, 3'd0, 3'd5, 3'd6});
        for (int k = 1; k <= 4; k++) begin
            v[k] = 16'($urandom);
            ciclo_c(1'b1, 3'(k), v[k], 12'h0);
        end
        ciclo_c(1'b0, 3'd0, 16'h0, {3'd4, 3'd3, 3'd2, 3'd1});
        for (int i = 0; i < 100; i++) begin
            wc = 3'($urandom);
            ciclo_c(1'($urandom_range(0, 1)), wc, 16'($urandom),
                    {3'($urandom), wc, 3'($urandom), 3'($urandom)});
        end
        faz_dump(1'b0, 1'b0);
        faz_dump(1'b1, 1'b1);
        reset_meio();
        espera_init();
        ciclo(1'b0, 5'd0, 32'h0, 5'd8, 5'd29);
        ciclo(1'b0, 5'd0, 32'h0, 5'd20, 5'd9);
        ciclo_c(1'b0, 3'd0, 16'h0, {3'd6, 3'd1, 3'd2, 3'd3});
        $display("Simulation finished: %0d checks, %0d errors", checks, erros);
        $finish;
    end
endmodule
